// File: rtl/nlc_input_sequencer_pkg.sv
// Shared constants and state encoding for the NLC input sequencer.
package nlc_input_sequencer_pkg;
    localparam int SAMPLE_W     = 21;
    localparam int OVF_CNT_W    = 8;
    localparam int ISSUED_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } seq_state_e;
endpackage

// File: rtl/nlc_input_sequencer_if.sv
// ADC sample stream in, NLC sample handshake out.
interface nlc_input_sequencer_if;
    import nlc_input_sequencer_pkg::*;

    logic                adc_valid;
    logic [SAMPLE_W-1:0] adc_data;
    logic                srdyi;
    logic [SAMPLE_W-1:0] x_adc;
    logic                srdyo;

    // master: the sequencer; slave: the ADC/NLC side
    modport master (input adc_valid, adc_data, srdyo, output srdyi, x_adc);
    modport slave  (output adc_valid, adc_data, srdyo, input srdyi, x_adc);
endinterface

// File: rtl/nlc_sample_fifo.sv
// Synchronous sample FIFO; the head comes straight from storage flops, so there is
// no fall-through path from push_data to head.
module nlc_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 21
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is legal only when a pop frees the slot the same edge.
    assign pop_ok  = pop && (level_q != '0);
    assign push_ok = push && ((level_q != (AW+1)'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign level = level_q;
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
endmodule

// File: rtl/nlc_input_sequencer.sv
// Buffers free-running ADC samples and hands them one at a time to the NLC,
// waiting for srdyo (or a timeout) before issuing the next.
module nlc_input_sequencer
    import nlc_input_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic                       clk,
    input  logic                       reset,
    nlc_input_sequencer_if.master      io,
    input  logic                       clear_flags,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       timeout,
    output logic [OVF_CNT_W-1:0]       overflow_cnt,
    output logic [ISSUED_CNT_W-1:0]    issued_cnt
);
    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    seq_state_e            state_q;
    seq_state_e            state_d;
    logic [TMR_W-1:0]      timer_q;
    logic                  srdyi_q;
    logic [SAMPLE_W-1:0]   x_adc_q;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [SAMPLE_W-1:0]   fifo_head;
    logic                  ovf_evt;
    logic                  to_evt;

    nlc_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (io.adc_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // The ADC cannot stall: a sample is lost only when no slot frees up this edge.
    assign fifo_push = io.adc_valid && (!fifo_full || fifo_pop);
    assign ovf_evt   = io.adc_valid && fifo_full && !fifo_pop;

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        to_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = ISSUE;
                    fifo_pop = 1'b1;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                // srdyo wins over an expiring timer
                if (io.srdyo) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    state_d = IDLE;
                    to_evt  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q    <= '0;
            srdyi_q    <= 1'b0;
            x_adc_q    <= '0;
            issued_cnt <= '0;
        end else begin
            srdyi_q <= (state_d == ISSUE);
            if (fifo_pop) x_adc_q <= fifo_head;
            if (state_q == ISSUE) begin
                timer_q    <= '0;
                issued_cnt <= issued_cnt + 1'b1;
            end else if (state_q == BUSY) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Sticky flags: a new event on the same edge as clear_flags takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (ovf_evt) begin
                overflow     <= 1'b1;
                overflow_cnt <= clear_flags ? OVF_CNT_W'(1) : sat_inc(overflow_cnt);
            end else if (clear_flags) begin
                overflow     <= 1'b0;
                overflow_cnt <= '0;
            end
            if (to_evt)           timeout <= 1'b1;
            else if (clear_flags) timeout <= 1'b0;
        end
    end

    assign busy     = (state_q != IDLE);
    assign io.srdyi = srdyi_q;
    assign io.x_adc = x_adc_q;
endmodule
